// File: rtl/coef_pair_sched_if.sv
// Signal bundle for coef_pair_sched: coefficient input stream and butterfly pair output.
interface coef_pair_sched_if #(
  parameter int DW = 14
);
  logic          mode;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [DW-1:0] u;
  logic [DW-1:0] v;
  logic          sel;
  logic          pair_valid;
  logic          res_valid;
  logic          blk_done;

  modport master (
    output mode, in_valid, in_data,
    input  in_ready, u, v, sel, pair_valid, res_valid, blk_done
  );

  modport slave (
    input  mode, in_valid, in_data,
    output in_ready, u, v, sel, pair_valid, res_valid, blk_done
  );
endinterface

// File: rtl/coef_pair_sched.sv
// Ping-pong coefficient buffer emitting (i, i+N/2) butterfly operand pairs, with per-mode
// latency tracking so results of different butterfly modes never collide.
module coef_pair_sched #(
  parameter int DW   = 14,
  parameter int N    = 16,
  parameter int Q    = 12289,
  parameter int LAT0 = 2,
  parameter int LAT1 = 6
) (
  input logic              clk,
  input logic              rst,
  coef_pair_sched_if.slave bus
);
  localparam int AW = $clog2(N);
  localparam int RW = AW - 1;
  localparam logic [AW-1:0] WCNT_LAST = AW'(N - 1);
  localparam logic [RW-1:0] RCNT_LAST = RW'(N / 2 - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, GAP = 2'd2} state_t;

  // One conditional subtraction is enough because every DW-bit input is below 2*Q.
  function automatic logic [DW-1:0] mod_reduce(input logic [DW-1:0] x);
    logic [31:0] xe;
    xe = 32'(x);
    if (xe >= 32'(Q)) mod_reduce = DW'(xe - 32'(Q));
    else              mod_reduce = x;
  endfunction

  logic [DW-1:0]   mem_r [2][N];
  logic [1:0]      full_r;
  logic [1:0]      bank_mode_r;
  logic            wb_r;
  logic            rb_r;
  logic [AW-1:0]   wcnt_r;
  logic [RW-1:0]   rcnt_r;
  state_t          state_r;
  logic [DW-1:0]   u_r;
  logic [DW-1:0]   v_r;
  logic            sel_r;
  logic            pair_valid_r;
  logic            blk_done_r;
  logic [LAT0-1:0] d0_r;
  logic [LAT1-1:0] d1_r;

  logic accept_s;
  logic wr_last_s;
  logic rd_last_s;
  logic empty_s;
  logic nb_s;
  logic start_ok_s;
  logic chain_ok_s;

  // Handshake decode and read-side scheduling conditions.
  always_comb begin
    accept_s   = bus.in_valid && !full_r[wb_r];
    wr_last_s  = accept_s && (wcnt_r == WCNT_LAST);
    rd_last_s  = (state_r == EMIT) && (rcnt_r == RCNT_LAST);
    empty_s    = (d0_r == {LAT0{1'b0}}) && (d1_r == {LAT1{1'b0}}) && !pair_valid_r;
    nb_s       = ~rb_r;
    start_ok_s = (bank_mode_r[rb_r] == sel_r) || empty_s;
    chain_ok_s = full_r[nb_s] && (bank_mode_r[nb_s] == bank_mode_r[rb_r]);
  end

  // Bank data store; contents are only meaningful while the matching full flag is set.
  always_ff @(posedge clk) begin
    if (accept_s) mem_r[wb_r][wcnt_r] <= mod_reduce(bus.in_data);
  end

  // Writer bookkeeping, reader FSM, registered pair outputs and result delay lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_r       <= 2'b00;
      bank_mode_r  <= 2'b00;
      wb_r         <= 1'b0;
      rb_r         <= 1'b0;
      wcnt_r       <= {AW{1'b0}};
      rcnt_r       <= {RW{1'b0}};
      state_r      <= IDLE;
      u_r          <= {DW{1'b0}};
      v_r          <= {DW{1'b0}};
      sel_r        <= 1'b0;
      pair_valid_r <= 1'b0;
      blk_done_r   <= 1'b0;
      d0_r         <= {LAT0{1'b0}};
      d1_r         <= {LAT1{1'b0}};
    end else begin
      d0_r[0] <= pair_valid_r && !sel_r;
      for (int i = 1; i < LAT0; i++) d0_r[i] <= d0_r[i-1];
      d1_r[0] <= pair_valid_r && sel_r;
      for (int i = 1; i < LAT1; i++) d1_r[i] <= d1_r[i-1];

      if (accept_s) begin
        if (wcnt_r == {AW{1'b0}}) bank_mode_r[wb_r] <= bus.mode;
        if (wr_last_s) begin
          full_r[wb_r] <= 1'b1;
          wb_r         <= ~wb_r;
          wcnt_r       <= {AW{1'b0}};
        end else begin
          wcnt_r <= wcnt_r + AW'(1);
        end
      end

      pair_valid_r <= 1'b0;
      blk_done_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (full_r[rb_r]) state_r <= start_ok_s ? EMIT : GAP;
        end
        // Hold off a mode change until every in-flight result has retired.
        GAP: begin
          if (empty_s) state_r <= EMIT;
        end
        EMIT: begin
          u_r          <= mem_r[rb_r][{1'b0, rcnt_r}];
          v_r          <= mem_r[rb_r][{1'b1, rcnt_r}];
          sel_r        <= bank_mode_r[rb_r];
          pair_valid_r <= 1'b1;
          rcnt_r       <= rcnt_r + RW'(1);
          if (rd_last_s) begin
            blk_done_r   <= 1'b1;
            full_r[rb_r] <= 1'b0;
            rb_r         <= nb_s;
            rcnt_r       <= {RW{1'b0}};
            if (chain_ok_s)        state_r <= EMIT;
            else if (full_r[nb_s]) state_r <= GAP;
            else                   state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = !full_r[wb_r];
  assign bus.u          = u_r;
  assign bus.v          = v_r;
  assign bus.sel        = sel_r;
  assign bus.pair_valid = pair_valid_r;
  assign bus.blk_done   = blk_done_r;
  assign bus.res_valid  = d0_r[LAT0-1] | d1_r[LAT1-1];
endmodule
